// File: rtl/scene_switch_ctl_pkg.sv
// Shared widths, scene ids and hit-test helpers for the scene controller slice.
package scene_switch_ctl_pkg;

  localparam int RGB_W         = 12;
  localparam int POS_W         = 12;
  localparam int SCENE_MENU    = 0;
  localparam int SCENE_GAME    = 1;
  localparam int SCENE_CREDITS = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } ctl_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Inclusive span test; widened by one bit so lo+len never wraps.
  function automatic logic in_span(input logic [POS_W-1:0] pos, input int lo, input int len);
    logic [POS_W:0] lo_e;
    logic [POS_W:0] hi_e;
    logic [POS_W:0] pos_e;
    lo_e  = (POS_W+1)'(lo);
    hi_e  = (POS_W+1)'(lo + len);
    pos_e = {1'b0, pos};
    return (pos_e >= lo_e) && (pos_e <= hi_e);
  endfunction

endpackage

// File: rtl/scene_switch_ctl_if.sv
// Bundle of mouse/button/timing inputs, per-source video and selected outputs.
interface scene_switch_ctl_if
  import scene_switch_ctl_pkg::*;
#(
  parameter int N_SCENES = 3,
  parameter int N_LEVELS = 2
);
  localparam int SEL_W = idx_width(N_SCENES);
  localparam int LVL_W = idx_width(N_LEVELS);

  logic                      i_vblnk_in;
  logic [POS_W-1:0]          i_xpos;
  logic [POS_W-1:0]          i_ypos;
  logic                      i_mouse_left;
  logic                      i_button;
  logic [N_SCENES-1:0]       i_src_vsync;
  logic [N_SCENES-1:0]       i_src_hsync;
  logic [RGB_W*N_SCENES-1:0] i_src_rgb;
  logic                      o_vsync_out;
  logic                      o_hsync_out;
  logic [RGB_W-1:0]          o_rgb_out;
  logic [SEL_W-1:0]          o_scene;
  logic [LVL_W-1:0]          o_level;
  logic                      o_scene_changed;

  modport master (
    output i_vblnk_in, i_xpos, i_ypos, i_mouse_left, i_button,
           i_src_vsync, i_src_hsync, i_src_rgb,
    input  o_vsync_out, o_hsync_out, o_rgb_out, o_scene, o_level, o_scene_changed
  );

  modport slave (
    input  i_vblnk_in, i_xpos, i_ypos, i_mouse_left, i_button,
           i_src_vsync, i_src_hsync, i_src_rgb,
    output o_vsync_out, o_hsync_out, o_rgb_out, o_scene, o_level, o_scene_changed
  );

endinterface

// File: rtl/scene_switch_ctl_debounce.sv
// Board button synchroniser + debouncer: one pulse per stable press, re-armed by a stable release.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 650000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  // r_armed=1 waits for a stable high level, r_armed=0 for a stable low one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_armed <= 1'b1;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      if (r_sync2 != r_armed) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_armed <= ~r_armed;
        r_pulse <= r_armed;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/scene_switch_ctl.sv
// Scene selector for the VGA pipeline: menu hit-testing, back button, vblank-aligned commit,
// difficulty level and the registered video source mux.
module scene_switch_ctl
  import scene_switch_ctl_pkg::*;
#(
  parameter int N_SCENES     = 3,
  parameter int N_LEVELS     = 2,
  parameter int BTN_X0       = 362,
  parameter int BTN_W        = 312,
  parameter int BTN_Y0       = 46,
  parameter int BTN_H        = 100,
  parameter int BTN_PITCH    = 192,
  parameter int LVL_Y0       = 622,
  parameter int DEBOUNCE_CYC = 650000
) (
  input logic                clk,
  input logic                rst,
  scene_switch_ctl_if.slave  bus
);

  localparam int SEL_W = idx_width(N_SCENES);
  localparam int LVL_W = idx_width(N_LEVELS);
  localparam logic [SEL_W-1:0] SEL_MENU = SEL_W'(SCENE_MENU);
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(N_LEVELS - 1);

  ctl_state_t       r_state;
  logic [SEL_W-1:0] r_scene;
  logic [SEL_W-1:0] r_pend_scene;
  logic [LVL_W-1:0] r_level;
  logic             r_scene_changed;
  logic             r_vblnk_q;
  logic             r_mouse_q;
  logic             r_vsync;
  logic             r_hsync;
  logic [RGB_W-1:0] r_rgb;

  logic             w_back;
  logic             w_click;
  logic             w_vblnk_rise;
  logic             w_x_in;
  logic             w_scene_hit;
  logic [SEL_W-1:0] w_hit_scene;
  logic             w_lvl_hit;
  logic [SEL_W-1:0] w_sel;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (bus.i_button),
    .o_pulse (w_back)
  );

  assign w_click      = bus.i_mouse_left & ~r_mouse_q;
  assign w_vblnk_rise = bus.i_vblnk_in & ~r_vblnk_q;

  // Button column hit test; scene buttons never overlap, the first match wins anyway.
  always_comb begin
    w_x_in      = in_span(bus.i_xpos, BTN_X0, BTN_W);
    w_lvl_hit   = w_x_in & in_span(bus.i_ypos, LVL_Y0, BTN_H);
    w_scene_hit = 1'b0;
    w_hit_scene = SEL_MENU;
    for (int i = 0; i < N_SCENES - 1; i++) begin
      if (w_x_in && !w_scene_hit && in_span(bus.i_ypos, BTN_Y0 + i * BTN_PITCH, BTN_H)) begin
        w_scene_hit = 1'b1;
        w_hit_scene = SEL_W'(i + 1);
      end else begin
        w_hit_scene = w_hit_scene;
      end
    end
  end

  // Out-of-range scene index falls back to source 0.
  always_comb begin
    if (int'(r_scene) < N_SCENES) begin
      w_sel = r_scene;
    end else begin
      w_sel = SEL_MENU;
    end
  end

  // Request/commit FSM with scene, level and change pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_scene         <= SEL_MENU;
      r_pend_scene    <= SEL_MENU;
      r_level         <= '0;
      r_scene_changed <= 1'b0;
      r_vblnk_q       <= 1'b0;
      r_mouse_q       <= 1'b0;
    end else begin
      r_vblnk_q       <= bus.i_vblnk_in;
      r_mouse_q       <= bus.i_mouse_left;
      r_scene_changed <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_scene == SEL_MENU) begin
            if (w_click && w_scene_hit) begin
              r_pend_scene <= w_hit_scene;
              r_state      <= ST_PENDING;
            end else if (w_click && w_lvl_hit) begin
              r_level <= (r_level == LVL_LAST) ? LVL_W'(0) : r_level + LVL_W'(1);
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_back) begin
            r_pend_scene <= SEL_MENU;
            r_state      <= ST_PENDING;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_PENDING: begin
          if (w_vblnk_rise) begin
            r_scene         <= r_pend_scene;
            r_scene_changed <= 1'b1;
            r_state         <= ST_IDLE;
          end else begin
            r_state <= ST_PENDING;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered source mux; follows r_scene one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync <= 1'b0;
      r_hsync <= 1'b0;
      r_rgb   <= '0;
    end else begin
      r_vsync <= bus.i_src_vsync[w_sel];
      r_hsync <= bus.i_src_hsync[w_sel];
      r_rgb   <= bus.i_src_rgb[int'(w_sel) * RGB_W +: RGB_W];
    end
  end

  assign bus.o_vsync_out     = r_vsync;
  assign bus.o_hsync_out     = r_hsync;
  assign bus.o_rgb_out       = r_rgb;
  assign bus.o_scene         = r_scene;
  assign bus.o_level         = r_level;
  assign bus.o_scene_changed = r_scene_changed;

endmodule

// File: tb/tb_scene_switch_ctl.sv
// Scenario bench for scene_switch_ctl: expected commits are queued at request time and popped on each pulse.
module tb_scene_switch_ctl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scene_switch_ctl_if #(.N_SCENES(3), .N_LEVELS(2)) bus ();

  scene_switch_ctl #(
    .N_SCENES     (3),
    .N_LEVELS     (2),
    .DEBOUNCE_CYC (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks  = 0;
  int n_fail    = 0;
  int n_changes = 0;
  int exp_scene_q[$];

  always @(negedge clk) begin
    if (bus.o_scene_changed === 1'b1) n_changes++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_click(input logic [11:0] x, input logic [11:0] y);
    bus.i_xpos = x;
    bus.i_ypos = y;
    bus.i_mouse_left = 1'b1;
    tick();
    bus.i_mouse_left = 1'b0;
    tick();
  endtask

  task automatic drive_back();
    bus.i_button = 1'b1; tick();
    bus.i_button = 1'b0; tick();
    bus.i_button = 1'b1;
    repeat (8) tick();
    bus.i_button = 1'b0;
    repeat (10) tick();
  endtask

  task automatic wait_commit(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (bus.o_scene_changed === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_vblnk_in = 1'b0; bus.i_xpos = 12'd0; bus.i_ypos = 12'd0;
    bus.i_mouse_left = 1'b0; bus.i_button = 1'b0;
    bus.i_src_vsync = 3'b101; bus.i_src_hsync = 3'b010;
    bus.i_src_rgb = {12'h333, 12'h222, 12'h111};
    repeat (3) tick();
    n_checks++;
    if (bus.o_rgb_out !== 12'h000 || bus.o_scene !== 2'd0 || bus.o_level !== 1'b0 || bus.o_scene_changed !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rgb=%h scene=%0d level=%0d chg=%b, required 000/0/0/0",
               bus.o_rgb_out, bus.o_scene, bus.o_level, bus.o_scene_changed);
    end
    rst = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (bus.o_rgb_out !== 12'h111 || bus.o_vsync_out !== 1'b1 || bus.o_hsync_out !== 1'b0) begin
      n_fail++;
      $display("FAIL menu_source: rgb=%h v=%b h=%b, required 111/1/0", bus.o_rgb_out, bus.o_vsync_out, bus.o_hsync_out);
    end
  endtask

  task automatic test_click_scene();
    int c0; int exp; bit seen;
    c0 = n_changes;
    drive_click(12'd400, 12'd60);
    exp_scene_q.push_back(1);
    repeat (5) tick();
    n_checks++;
    if (bus.o_scene !== 2'd0 || n_changes != c0) begin
      n_fail++;
      $display("FAIL click_waits_vblank: scene=%0d changes=%0d, required 0/%0d", bus.o_scene, n_changes, c0);
    end
    bus.i_vblnk_in = 1'b1;
    wait_commit(seen);
    exp = (exp_scene_q.size() > 0) ? exp_scene_q.pop_front() : -1;
    n_checks++;
    if (!seen || int'(bus.o_scene) != exp || bus.o_rgb_out !== 12'h111) begin
      n_fail++;
      $display("FAIL commit_scene1: seen=%b scene=%0d rgb=%h, required 1/%0d/111", seen, bus.o_scene, bus.o_rgb_out, exp);
    end
    tick();
    n_checks++;
    if (bus.o_rgb_out !== 12'h222 || bus.o_scene_changed !== 1'b0 || bus.o_vsync_out !== 1'b0 || bus.o_hsync_out !== 1'b1) begin
      n_fail++;
      $display("FAIL scene1_source: rgb=%h chg=%b v=%b h=%b, required 222/0/0/1",
               bus.o_rgb_out, bus.o_scene_changed, bus.o_vsync_out, bus.o_hsync_out);
    end
    bus.i_vblnk_in = 1'b0;
    tick();
  endtask

  task automatic test_back();
    int c0; int exp; bit seen;
    c0 = n_changes;
    drive_back();
    exp_scene_q.push_back(0);
    n_checks++;
    if (bus.o_scene !== 2'd1 || n_changes != c0) begin
      n_fail++;
      $display("FAIL back_waits_vblank: scene=%0d changes=%0d, required 1/%0d", bus.o_scene, n_changes, c0);
    end
    bus.i_vblnk_in = 1'b1;
    wait_commit(seen);
    exp = (exp_scene_q.size() > 0) ? exp_scene_q.pop_front() : -1;
    n_checks++;
    if (!seen || int'(bus.o_scene) != exp) begin
      n_fail++;
      $display("FAIL commit_back: seen=%b scene=%0d, required 1/%0d", seen, bus.o_scene, exp);
    end
    bus.i_vblnk_in = 1'b0; repeat (3) tick();
    bus.i_vblnk_in = 1'b1; repeat (3) tick();
    bus.i_vblnk_in = 1'b0; tick();
    n_checks++;
    if (n_changes != c0 + 1 || bus.o_rgb_out !== 12'h111) begin
      n_fail++;
      $display("FAIL single_back: changes=%0d rgb=%h, required %0d/111", n_changes, bus.o_rgb_out, c0 + 1);
    end
  endtask

  task automatic test_level();
    int c0;
    c0 = n_changes;
    bus.i_xpos = 12'd400; bus.i_ypos = 12'd630;
    bus.i_mouse_left = 1'b1;
    tick();
    n_checks++;
    if (bus.o_level !== 1'b1) begin
      n_fail++;
      $display("FAIL level_immediate: level=%0d, required 1", bus.o_level);
    end
    repeat (99) tick();
    bus.i_mouse_left = 1'b0;
    tick();
    n_checks++;
    if (bus.o_level !== 1'b1 || bus.o_scene !== 2'd0) begin
      n_fail++;
      $display("FAIL level_hold_once: level=%0d scene=%0d, required 1/0", bus.o_level, bus.o_scene);
    end
    drive_click(12'd400, 12'd630);
    bus.i_vblnk_in = 1'b1; repeat (3) tick();
    bus.i_vblnk_in = 1'b0; tick();
    n_checks++;
    if (bus.o_level !== 1'b0 || n_changes != c0) begin
      n_fail++;
      $display("FAIL level_wrap: level=%0d changes=%0d, required 0/%0d", bus.o_level, n_changes, c0);
    end
  endtask

  task automatic test_first_wins();
    int exp; bit seen;
    drive_click(12'd400, 12'd250);
    exp_scene_q.push_back(2);
    drive_click(12'd400, 12'd60);
    bus.i_vblnk_in = 1'b1;
    wait_commit(seen);
    exp = (exp_scene_q.size() > 0) ? exp_scene_q.pop_front() : -1;
    tick();
    n_checks++;
    if (!seen || int'(bus.o_scene) != exp || bus.o_rgb_out !== 12'h333 || bus.o_vsync_out !== 1'b1) begin
      n_fail++;
      $display("FAIL first_wins: seen=%b scene=%0d rgb=%h, required 1/%0d/333", seen, bus.o_scene, bus.o_rgb_out, exp);
    end
    bus.i_vblnk_in = 1'b0; tick();
    drive_click(12'd400, 12'd630);
    n_checks++;
    if (bus.o_level !== 1'b0) begin
      n_fail++;
      $display("FAIL level_frozen: level=%0d, required 0", bus.o_level);
    end
    drive_back();
    exp_scene_q.push_back(0);
    bus.i_vblnk_in = 1'b1;
    wait_commit(seen);
    exp = (exp_scene_q.size() > 0) ? exp_scene_q.pop_front() : -1;
    n_checks++;
    if (!seen || int'(bus.o_scene) != exp) begin
      n_fail++;
      $display("FAIL back_from_scene2: seen=%b scene=%0d, required 1/%0d", seen, bus.o_scene, exp);
    end
    bus.i_vblnk_in = 1'b0; tick();
  endtask

  task automatic test_boundaries();
    int c0; int exp; bit seen;
    c0 = n_changes;
    drive_click(12'd361, 12'd60);
    drive_click(12'd400, 12'd147);
    bus.i_vblnk_in = 1'b1; repeat (3) tick();
    bus.i_vblnk_in = 1'b0; tick();
    n_checks++;
    if (bus.o_scene !== 2'd0 || n_changes != c0) begin
      n_fail++;
      $display("FAIL outside_click: scene=%0d changes=%0d, required 0/%0d", bus.o_scene, n_changes, c0);
    end
    drive_click(12'd674, 12'd146);
    exp_scene_q.push_back(1);
    bus.i_vblnk_in = 1'b1;
    wait_commit(seen);
    exp = (exp_scene_q.size() > 0) ? exp_scene_q.pop_front() : -1;
    n_checks++;
    if (!seen || int'(bus.o_scene) != exp) begin
      n_fail++;
      $display("FAIL inclusive_corner: seen=%b scene=%0d, required 1/%0d", seen, bus.o_scene, exp);
    end
    bus.i_vblnk_in = 1'b0; tick();
    drive_back();
    exp_scene_q.push_back(0);
    bus.i_vblnk_in = 1'b1;
    wait_commit(seen);
    exp = (exp_scene_q.size() > 0) ? exp_scene_q.pop_front() : -1;
    n_checks++;
    if (!seen || int'(bus.o_scene) != exp) begin
      n_fail++;
      $display("FAIL corner_return: seen=%b scene=%0d, required 1/%0d", seen, bus.o_scene, exp);
    end
    bus.i_vblnk_in = 1'b0; tick();
  endtask

  task automatic test_reset_pending();
    int c0;
    c0 = n_changes;
    drive_click(12'd400, 12'd60);
    rst = 1'b1; tick();
    rst = 1'b0;
    bus.i_vblnk_in = 1'b1; repeat (4) tick();
    bus.i_vblnk_in = 1'b0; tick();
    n_checks++;
    if (bus.o_scene !== 2'd0 || n_changes != c0 || bus.o_rgb_out !== 12'h111) begin
      n_fail++;
      $display("FAIL reset_discards_pending: scene=%0d changes=%0d rgb=%h, required 0/%0d/111",
               bus.o_scene, n_changes, bus.o_rgb_out, c0);
    end
  endtask

  initial begin
    test_reset();
    test_click_scene();
    test_back();
    test_level();
    test_first_wins();
    test_boundaries();
    test_reset_pending();
    n_checks++;
    if (exp_scene_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drained: %0d left, required 0", exp_scene_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
